serdes_tx_sched: RTL
====================

Name: serdes_tx_sched

Overview:
- Transmit-side scheduler that sequences the byte-wide serializer and shares it between two byte requesters.
- Runs an 8-clock slot timer; at each slot boundary it loads exactly one byte into the serializer.
- The byte is COM training symbols after reset, a periodic COM sync, a granted requester byte, or IDL filler.
- Sits between the link-layer requesters and the serializer; the matching deserializer aligns on the COM symbols.

Parameters:
- TRAIN_COM_CNT, 4, number of COM slots sent after reset before the link goes active (1..15).
- SYNC_PERIOD, 16, active slots per forced COM insertion; 0 disables periodic sync.
- COM_SYM, 8'hBC, comma/alignment symbol.
- IDL_SYM, 8'h7C, idle filler symbol.

Ports:
- clk  input  1  system clock, rising edge.
- reset_L  input  1  asynchronous active-low reset.
- enb  input  1  global enable; low freezes all state.
- req0  input  1  requester 0 has a byte pending.
- data0  input  8  requester 0 byte.
- req1  input  1  requester 1 has a byte pending.
- data1  input  8  requester 1 byte.
- gnt0  output  1  one-cycle pulse: data0 consumed.
- gnt1  output  1  one-cycle pulse: data1 consumed.
- ser_data  output  8  byte presented to the serializer.
- ser_load  output  1  one-cycle load strobe to the serializer.
- ser_enb  output  1  serializer enable; high whenever enb is high and not in reset.
- link_active  output  1  high once training is complete.

Behaviour:
- Reset (reset_L low, asynchronous), all registered:
  - slot counter cnt = 0, state = TRAIN, training count = 0, sync count = 0, round-robin pointer = 0.
  - ser_data = 8'h00; ser_load, gnt0, gnt1, ser_enb, link_active = 0.
- enb low: every register holds; ser_load, gnt0 and gnt1 are forced low; ser_enb = 0. Operation resumes exactly where it stopped.
- cnt is 3 bits and increments on every enabled edge, wrapping 7 -> 0.
- Slot boundary: the enabled edge at which cnt == 7.
  - At that edge: ser_data is updated and ser_load = 1 for exactly one cycle.
  - Between boundaries ser_data holds its value.
  - The first boundary after reset is the 8th enabled edge.
- State TRAIN:
  - Each boundary loads COM_SYM and increments the training count.
  - The boundary that loads the TRAIN_COM_CNT-th COM moves the state to ACTIVE.
  - Requests are ignored and gnt0/gnt1 stay 0.
- State ACTIVE: link_active = 1 from the first ACTIVE boundary onward. Each boundary applies, in priority order:
  1. If SYNC_PERIOD != 0 and sync count == SYNC_PERIOD-1: load COM_SYM, clear sync count, issue no grant.
  2. Else if req0 or req1 is high: select by round-robin, load the selected dataN, pulse gntN with ser_load, and set the pointer so the other requester has priority next. Sync count increments.
  3. Else: load IDL_SYM; sync count increments.
- Round-robin:
  - pointer = 0 means requester 0 is preferred.
  - A single active request always wins.
  - With both requests active, grants alternate.
  - The pointer changes only on a grant.
- Request handshake:
  - req/data are sampled only at the boundary edge.
  - A requester holds req and data stable until it sees its gnt. It may deassert or change data on the cycle gnt is high.
  - A req that drops before a boundary is not granted.
- Latency: a request asserted at least one cycle before a boundary is loaded at that boundary, unless it is a sync slot or loses arbitration.
- Reset mid-slot or mid-training: immediate return to the reset values; training restarts from 0 and link_active falls.
- ACTIVE never returns to TRAIN except through reset.

Optional Feature:
- Macro: SER_PARITY_EN.
- When defined:
  - Adds output ser_par (1 bit), registered together with ser_data.
  - ser_par = XOR of the 8 bits of the loaded byte (even parity), forming a 9-bit serial word.
  - Reset value is 0; it holds when enb is low.
- When not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, enb=1, no requests, defaults:
  - ser_load pulses at enabled edges 8, 16, 24 and 32 with ser_data=BC.
  - Edge 40 loads 7C and link_active rises.
- After ACTIVE, req0=1 with data0=A5 held:
  - The next boundary loads A5, with gnt0=1 and ser_load=1 in the same cycle.
  - Dropping req0 afterwards gives 7C at the following boundary.
- req0=req1=1 continuously, data0=11, data1=22:
  - Loads alternate 11, 22, 11, 22.
  - gnt0 and gnt1 alternate, never both high.
- SYNC_PERIOD=4, req0 held high:
  - Every 4th active slot carries BC with gnt0=0.
  - The other three slots carry data0 with gnt0 pulses.
- enb low for 5 cycles at cnt=3:
  - No ser_load and ser_enb=0 during the stall.
  - The next boundary arrives 5 cycles late with the expected byte.
- reset_L pulsed low during ACTIVE: outputs clear immediately; full 4-COM training repeats.
- With SER_PARITY_EN defined: a load of A5 gives ser_par=0, a load of 07 gives ser_par=1, and a load of BC gives ser_par=1.

Source files
------------

// File: rtl/serdes_tx_sched.sv
// Transmit slot scheduler: feeds one byte per 8-clock slot to the serializer, sharing it between two requesters.
// Latency: a request sampled at a slot boundary edge is loaded (ser_data/ser_load/gntN) on that same edge.
// Backpressure: requesters hold req/data until gntN; enb low freezes all state and masks strobes.
//
// Ports:
//   clk, reset_L          clock (rising edge), asynchronous active-low reset
//   enb                   global enable; low holds every register, masks ser_load/gnt0/gnt1/ser_enb
//   req0/data0, req1/data1  requester byte offers; gnt0/gnt1 one-cycle consume pulses
//   ser_data, ser_load    byte and load strobe to the serializer
//   ser_enb               serializer enable
//   link_active           high once COM training has completed
//   ser_par               (only with SER_PARITY_EN defined) even parity of ser_data
//
// Optional feature macro: SER_PARITY_EN
module serdes_tx_sched #(
  parameter int          TRAIN_COM_CNT = 4,
  parameter int          SYNC_PERIOD   = 16,
  parameter logic [7:0]  COM_SYM       = 8'hBC,
  parameter logic [7:0]  IDL_SYM       = 8'h7C
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       enb,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] ser_data,
  output logic       ser_load,
  output logic       ser_enb,
  output logic       link_active
`ifdef SER_PARITY_EN
  ,
  output logic       ser_par
`endif
);

  // Sync counter only needs to reach SYNC_PERIOD-1.
  localparam int SW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [SW-1:0] SYNC_LAST  = SW'(SYNC_PERIOD - 1);
  localparam logic [3:0]    TRAIN_LAST = 4'(TRAIN_COM_CNT - 1);

  typedef enum logic {TRAIN, ACTIVE} state_t;

  state_t        state, nxt_state;
  logic [2:0]    cnt;
  logic [3:0]    train_cnt, nxt_train_cnt;
  logic [SW-1:0] sync_cnt, nxt_sync_cnt;
  logic          rr_ptr, nxt_rr_ptr;
  logic [7:0]    nxt_data;
  logic          nxt_gnt0, nxt_gnt1, nxt_link;
  logic          boundary, sync_hit, pick1;

  // The boundary qualifier includes enb, so every "next" value below
  // collapses to a hold (or to zero for strobes) while disabled.
  assign boundary = enb && (cnt == 3'd7);
  assign sync_hit = (SYNC_PERIOD != 0) && (sync_cnt == SYNC_LAST);
  // Requester 1 wins when it is alone or when the pointer prefers it.
  assign pick1    = req1 && (!req0 || rr_ptr);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= TRAIN;
    else          state <= nxt_state;
  end

  always_comb begin
    nxt_state     = state;
    nxt_train_cnt = train_cnt;
    nxt_sync_cnt  = sync_cnt;
    nxt_rr_ptr    = rr_ptr;
    nxt_data      = ser_data;
    nxt_gnt0      = 1'b0;
    nxt_gnt1      = 1'b0;
    nxt_link      = link_active;
    if (boundary) begin
      case (state)
        TRAIN: begin
          nxt_data      = COM_SYM;
          nxt_train_cnt = train_cnt + 4'd1;
          if (train_cnt == TRAIN_LAST) nxt_state = ACTIVE;
        end
        ACTIVE: begin
          nxt_link = 1'b1;
          if (sync_hit) begin
            nxt_data     = COM_SYM;
            nxt_sync_cnt = '0;
          end else if (req0 || req1) begin
            nxt_sync_cnt = sync_cnt + SW'(1);
            if (pick1) begin
              nxt_data   = data1;
              nxt_gnt1   = 1'b1;
              nxt_rr_ptr = 1'b0;
            end else begin
              nxt_data   = data0;
              nxt_gnt0   = 1'b1;
              nxt_rr_ptr = 1'b1;
            end
          end else begin
            nxt_data     = IDL_SYM;
            nxt_sync_cnt = sync_cnt + SW'(1);
          end
        end
        default: nxt_state = TRAIN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt         <= 3'd0;
      train_cnt   <= 4'd0;
      sync_cnt    <= '0;
      rr_ptr      <= 1'b0;
      ser_data    <= 8'h00;
      ser_load    <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      ser_enb     <= 1'b0;
      link_active <= 1'b0;
    end else begin
      if (enb) cnt <= cnt + 3'd1;
      train_cnt   <= nxt_train_cnt;
      sync_cnt    <= nxt_sync_cnt;
      rr_ptr      <= nxt_rr_ptr;
      ser_data    <= nxt_data;
      ser_load    <= boundary;
      gnt0        <= nxt_gnt0;
      gnt1        <= nxt_gnt1;
      ser_enb     <= enb;
      link_active <= nxt_link;
    end
  end

`ifdef SER_PARITY_EN
  // Ninth serial bit: even parity over the byte loaded at the same edge.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)      ser_par <= 1'b0;
    else if (boundary) ser_par <= ^nxt_data;
  end
`endif

endmodule
